dmem_lsu: RTL
=============

# dmem_lsu

Load/store unit between the execute stage of `riscvcpucore` and the word-organised data memory `U_dmem`. It accepts one RV32I memory operation at a time from execute, drives the data memory with a 1-cycle registered-read protocol, and performs byte-lane steering for stores and extraction/extension for loads. It returns load results to writeback and flags misaligned or illegal accesses.

## Interface
- `DMEM_AW`, 10: word-address width of data memory, giving 2^DMEM_AW 32-bit words.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  execute presents a memory operation.
- `req_ready`  out  1  unit can accept; `req_ready = (state==IDLE) && !rst`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2).
- `req_addr`  in  32  effective byte address.
- `req_wdata`  in  32  store source register value.
- `req_rd`  in  5  load destination register.
- `dmem_en`  out  1  memory access strobe.
- `dmem_we`  out  4  byte write enables; bit i = bits [8i+7:8i].
- `dmem_addr`  out  DMEM_AW  word index, `req_addr[DMEM_AW+1:2]`.
- `dmem_wdata`  out  32  lane-steered store data.
- `dmem_rdata`  in  32  read word, valid the cycle after the `dmem_en` cycle.
- `wb_valid`  out  1  one-cycle pulse: load result available.
- `wb_rd`  out  5  destination of the returned load.
- `wb_data`  out  32  extended load result.
- `err_valid`  out  1  one-cycle pulse: misaligned or illegal request.
- `err_addr`  out  32  offending `req_addr`.

## Operation
- FSM states: IDLE, ACCESS, DATA. The handshake completes when `req_valid && req_ready`. On acceptance the request is latched, so upstream may change its signals afterwards.
- Legality:
  - LH/LHU/SH require `addr[0]==0`.
  - LW/SW require `addr[1:0]==0`.
  - Loads with funct3 3, 6 or 7 are illegal.
  - Stores with funct3 of 3 or more are illegal.
- Illegal request:
  - Register `err_valid=1` and `err_addr`.
  - State stays IDLE.
  - No memory access, no `wb_valid`.
- Legal request: IDLE -> ACCESS. The `dmem_*` outputs are registered at the accept edge.
  - SB: `dmem_we = 1<<addr[1:0]`, `dmem_wdata = {4{wdata[7:0]}}`.
  - SH: `dmem_we = addr[1] ? 4'b1100 : 4'b0011`, `dmem_wdata = {2{wdata[15:0]}}`.
  - SW: `dmem_we = 4'b1111`, `dmem_wdata = wdata`.
  - Loads: `dmem_we = 0`, `dmem_en = 1`.
- ACCESS, store: -> IDLE and clear `dmem_en`/`dmem_we`.
- ACCESS, load: -> DATA and clear `dmem_en`.
- DATA: capture `dmem_rdata`, extract, register `wb_valid=1`, `wb_rd`, `wb_data`; -> IDLE.
- Load extraction:
  - LB/LBU: byte lane `addr[1:0]`, sign-/zero-extended.
  - LH/LHU: half lane `addr[1]`, sign-/zero-extended.
  - LW: whole word.
- `rd==0` loads are performed and reported normally; the regfile discards x0 writes.
- `wb_valid` and `err_valid` are never high in the same cycle.

## Timing
- Reset values:
  - state IDLE.
  - `dmem_en`, `dmem_we`, `dmem_addr`, `dmem_wdata` all 0.
  - `wb_valid`, `wb_rd`, `wb_data` all 0.
  - `err_valid`, `err_addr` both 0.
  - `req_ready` 0 while `rst` is high.
- Store, accepted at edge E0:
  - `dmem_en`/`dmem_we` high for exactly the cycle after E0.
  - `req_ready` low that cycle and high after E1.
  - Throughput: 1 store per 2 cycles.
- Load, accepted at E0:
  - `dmem_en` high for the E0-E1 cycle.
  - `wb_valid` pulses for the cycle after E2.
  - `req_ready` is low after E0 and after E1, and high again after E2. A new request may be accepted at E3.
- Illegal request at E0: `err_valid` high for one cycle after E0; `req_ready` stays high, so back-to-back requests are allowed.
- `rst` asserted in ACCESS or DATA:
  - All outputs clear immediately (asynchronously).
  - The pending load produces no `wb_valid`.
  - An in-flight store strobe is dropped.
- `req_valid` high outside IDLE is ignored; it is not accepted until `req_ready` is high.

## Test plan
- SW `wdata=0x12345678`, `addr=8`: `dmem_en=1`, `dmem_we=1111`, `dmem_addr=2` for one cycle. Then LW `addr=8`, `rd=14`: 2 cycles after accept, `wb_valid=1`, `wb_rd=14`, `wb_data=0x12345678`.
- SB `wdata=38`, `addr=5`: `dmem_we=0010`, `dmem_wdata=0x26262626`. With word 1 = `0x80F01234`:
  - LB `addr=7` -> `0xFFFFFF80`.
  - LBU `addr=7` -> `0x00000080`.
- Half-word accesses with word 1 = `0x80F01234`:
  - LH `addr=6` -> `0xFFFF80F0`.
  - LHU `addr=6` -> `0x000080F0`.
  - SH `wdata=0x5C`, `addr=14` -> `dmem_we=1100`, `dmem_addr=3`, `dmem_wdata=0x005C005C`.
- Illegal requests: LW `addr=6` -> `err_valid` pulse, `err_addr=6`, `dmem_en` stays 0, `req_ready` stays 1. Load with funct3=3 -> `err_valid` pulse as well.
- Back-to-back: `req_valid` held with a load followed by a store. `req_ready` is low for exactly 2 cycles after the load accept, and the store is accepted at E3.
- `rst` pulsed while in DATA: `wb_valid` never rises, all outputs 0. The first LW after reset release completes with correct data.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between execute and the word-organised data memory.
// Accepts one RV32I memory operation at a time, drives a 1-cycle registered-read
// memory, steers store bytes onto lanes, and extracts/extends load results.
// Misaligned or illegal requests are reported on err_* without touching memory.
module dmem_lsu #(
    parameter int DMEM_AW = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [4:0]         req_rd,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    output logic               wb_valid,
    output logic [4:0]         wb_rd,
    output logic [31:0]        wb_data,
    output logic               err_valid,
    output logic [31:0]        err_addr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t             state_q;

    // Request fields kept for the load return path
    logic               is_store_q;
    logic [2:0]         funct3_q;
    logic [1:0]         lane_q;
    logic [4:0]         rd_q;

    // Registered outputs
    logic               dmem_en_q;
    logic [3:0]         dmem_we_q;
    logic [DMEM_AW-1:0] dmem_addr_q;
    logic [31:0]        dmem_wdata_q;
    logic               wb_valid_q;
    logic [4:0]         wb_rd_q;
    logic [31:0]        wb_data_q;
    logic               err_valid_q;
    logic [31:0]        err_addr_q;

    // Next-value decode for the accept edge and the data edge
    logic               legal_d;
    logic [3:0]         st_we_d;
    logic [31:0]        st_wdata_d;
    logic [31:0]        ld_data_d;

    // Legality: funct3 must name a real access of this direction, and the
    // address must be aligned to the access size.
    function automatic logic is_legal(input logic       we,
                                      input logic [2:0] f3,
                                      input logic [1:0] lo);
        logic ok;
        case (f3)
            3'd0:    ok = 1'b1;
            3'd1:    ok = ~lo[0];
            3'd2:    ok = (lo == 2'b00);
            3'd4:    ok = ~we;
            3'd5:    ok = ~we & ~lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-enable pattern for a legal store
    function automatic logic [3:0] store_we(input logic [2:0] f3,
                                            input logic [1:0] lane);
        logic [3:0] m;
        case (f3)
            3'd0:    m = 4'b0001 << lane;
            3'd1:    m = lane[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Store data is replicated across all lanes; the byte enables pick the
    // lane that actually gets written.
    function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                                input logic [31:0] wd);
        logic [31:0] r;
        case (f3)
            3'd0:    r = {4{wd[7:0]}};
            3'd1:    r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pull the addressed byte/half out of the read word and extend it
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'h0, b};
            3'd5:    r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Decode the incoming request and the returning read word
    always_comb begin
        legal_d    = is_legal(req_we, req_funct3, req_addr[1:0]);
        st_we_d    = store_we(req_funct3, req_addr[1:0]);
        st_wdata_d = store_wdata(req_funct3, req_wdata);
        ld_data_d  = load_extract(funct3_q, lane_q, dmem_rdata);
    end

    // Ready only in IDLE and never while reset is asserted
    assign req_ready = (state_q == IDLE) && !rst;

    // Control FSM with all outputs registered; pulses default low each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'd0;
            lane_q       <= 2'd0;
            rd_q         <= 5'd0;
            dmem_en_q    <= 1'b0;
            dmem_we_q    <= 4'd0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= 32'd0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'd0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= 32'd0;
        end else begin
            wb_valid_q  <= 1'b0;
            err_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        if (!legal_d) begin
                            // Rejected request: report and stay ready
                            err_valid_q <= 1'b1;
                            err_addr_q  <= req_addr;
                        end else begin
                            is_store_q  <= req_we;
                            funct3_q    <= req_funct3;
                            lane_q      <= req_addr[1:0];
                            rd_q        <= req_rd;
                            dmem_en_q   <= 1'b1;
                            dmem_we_q   <= req_we ? st_we_d : 4'd0;
                            dmem_addr_q <= req_addr[DMEM_AW+1:2];
                            if (req_we) begin
                                dmem_wdata_q <= st_wdata_d;
                            end
                            state_q <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Strobe lasts exactly one cycle; loads wait for the read word
                    dmem_en_q <= 1'b0;
                    dmem_we_q <= 4'd0;
                    state_q   <= is_store_q ? IDLE : DATA;
                end
                DATA: begin
                    wb_valid_q <= 1'b1;
                    wb_rd_q    <= rd_q;
                    wb_data_q  <= ld_data_d;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dmem_en    = dmem_en_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign err_valid  = err_valid_q;
    assign err_addr   = err_addr_q;

endmodule
